// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared helpers and status-bit indices for the parametrised FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FULL_BIT   = 0;
  localparam int EMPTY_BIT  = 1;
  localparam int AFULL_BIT  = 2;
  localparam int AEMPTY_BIT = 3;
  localparam int OVF_BIT    = 4;
  localparam int UDF_BIT    = 5;
  localparam int STATUS_W   = 6;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem_dp.sv
// ============================================================================
// Module   : fifo_mem_dp
// Brief    : Simple dual-port RAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array kept reset-free so it maps onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-address write at full returns the old entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_ram_param.sv
// ============================================================================
// Module   : fifo_ram_param
// Brief    : Parametrised synchronous FIFO with occupancy, watermarks, errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = clog2(DEPTH),
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [STATUS_W-1:0]   w_status;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = enable & pop & ~w_empty;
  // At full a concurrent accepted pop frees the slot the push lands in.
  assign w_push_ok = enable & push & (~w_full | w_pop_ok);
  assign w_ovf_set = enable & push & ~w_push_ok;
  assign w_udf_set = enable & pop & ~w_pop_ok;

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_we    (w_push_ok),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_re    (w_pop_ok),
    .i_raddr (r_rptr),
    .o_rdata (data_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear so an error on the clearing edge is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clear_err) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (clear_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[FULL_BIT]   = w_full;
    w_status[EMPTY_BIT]  = w_empty;
    w_status[AFULL_BIT]  = (r_count >= c_AFULL);
    w_status[AEMPTY_BIT] = (r_count <= c_AEMPTY);
    w_status[OVF_BIT]    = r_ovf;
    w_status[UDF_BIT]    = r_udf;
  end

  assign full         = w_status[FULL_BIT];
  assign empty        = w_status[EMPTY_BIT];
  assign almost_full  = w_status[AFULL_BIT];
  assign almost_empty = w_status[AEMPTY_BIT];
  assign overflow     = w_status[OVF_BIT];
  assign underflow    = w_status[UDF_BIT];
  assign count        = r_count;

endmodule

`default_nettype wire
